// File: rtl/sdp_shared_fifo_ctrl_pkg.sv
// Shared definitions for the shared-FIFO controller.
//   fifo_cnt_t      : occupancy type for the default 9-bit address (0..512)
//   GNT_P0 / GNT_P1 : encoding of the write-port winner and of last_grant
package sdp_shared_fifo_ctrl_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 9;

  typedef logic [FIFO_ADDR_WIDTH:0] fifo_cnt_t;

  localparam logic GNT_P0 = 1'b0;
  localparam logic GNT_P1 = 1'b1;

endpackage

// File: rtl/sdp_shared_fifo_ctrl_ram.sv
// Simple dual-port RAM: one synchronous write port and one synchronous read
// port. A read at the same edge as a write to the same address returns the
// old contents. The contents have no reset.
// Ports:
//   clk           : clock
//   wr_en         : write strobe
//   write_address : write location
//   write_data    : write word
//   read_address  : read location, sampled at the rising edge
//   read_data     : word at read_address, one edge later
module simple_dual_port #(
  parameter int address_width = 9,
  parameter int word_length   = 40
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [address_width-1:0] write_address,
  input  logic [word_length-1:0]   write_data,
  input  logic [address_width-1:0] read_address,
  output logic [word_length-1:0]   read_data
);

  logic [word_length-1:0] mem_q [1 << address_width];

  // Storage write and registered read; non-blocking update gives read-old-data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[write_address] <= write_data;
    end
    read_data <= mem_q[read_address];
  end

endmodule

// File: rtl/sdp_shared_fifo_ctrl.sv
// Shared first-word-fall-through FIFO built on one simple dual-port RAM.
// Two producers are arbitrated round-robin onto the RAM write port; one
// consumer drains through a valid/ready port with zero bubbles.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   wr0_valid/data/ready : producer 0 (ready = word accepted this cycle)
//   wr1_valid/data/ready : producer 1
//   rd_valid/data/ready  : consumer; pop = rd_valid & rd_ready
//   count                : committed occupancy
//   full / empty         : count == DEPTH / count == 0 (registered)
module sdp_shared_fifo_ctrl
  import sdp_shared_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr0_valid,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_ready,
  input  logic                  wr1_valid,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   avail_q, avail_d;
  logic                  commit_q;
  logic                  last_grant_q, last_grant_d;
  logic                  full_q, empty_q, rd_valid_q;

  logic                  grant_s;
  logic                  winner_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] ram_wdata_s;
  logic [ADDR_WIDTH-1:0] ram_raddr_s;

  // Round-robin winner: a lone requester wins; on a tie the one that did not
  // win last time goes.
  always_comb begin
    winner_s = GNT_P0;
    if (wr0_valid && wr1_valid) begin
      if (last_grant_q == GNT_P0) begin
        winner_s = GNT_P1;
      end else begin
        winner_s = GNT_P0;
      end
    end else if (wr1_valid) begin
      winner_s = GNT_P1;
    end else begin
      winner_s = GNT_P0;
    end
  end

  // full is the registered view of count, so a same-cycle pop cannot free a
  // slot for a write.
  assign grant_s     = !full_q && (wr0_valid || wr1_valid);
  assign wr0_ready   = grant_s && (winner_s == GNT_P0);
  assign wr1_ready   = grant_s && (winner_s == GNT_P1);
  assign ram_wdata_s = (winner_s == GNT_P1) ? wr1_data : wr0_data;

  assign pop_s       = rd_valid_q && rd_ready;
  // Look ahead past the word being popped so the next head is on read_data
  // right after this edge.
  assign ram_raddr_s = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, pop_s};

  // Next-state for pointers and occupancy accounting.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_grant_d = last_grant_q;
    if (grant_s) begin
      wr_ptr_d     = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      last_grant_d = winner_s;
    end else begin
      wr_ptr_d     = wr_ptr_q;
      last_grant_d = last_grant_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {{ADDR_WIDTH{1'b0}}, grant_s} - {{ADDR_WIDTH{1'b0}}, pop_s};
    // A written word becomes readable one edge later than it is counted,
    // because the RAM returns old data on a same-edge read of that address.
    avail_d = avail_q + {{ADDR_WIDTH{1'b0}}, commit_q} - {{ADDR_WIDTH{1'b0}}, pop_s};
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q     <= {ADDR_WIDTH{1'b0}};
      count_q      <= CNT_ZERO;
      avail_q      <= CNT_ZERO;
      commit_q     <= 1'b0;
      last_grant_q <= GNT_P1;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      avail_q      <= avail_d;
      commit_q     <= grant_s;
      last_grant_q <= last_grant_d;
      full_q       <= (count_d == DEPTH);
      empty_q      <= (count_d == CNT_ZERO);
      rd_valid_q   <= (avail_d != CNT_ZERO);
    end
  end

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

  simple_dual_port #(
    .address_width (ADDR_WIDTH),
    .word_length   (DATA_WIDTH)
  ) u_ram (
    .clk           (clk),
    .wr_en         (grant_s),
    .write_address (wr_ptr_q),
    .write_data    (ram_wdata_s),
    .read_address  (ram_raddr_s),
    .read_data     (rd_data)
  );

endmodule

// File: tb/tb_sdp_shared_fifo_ctrl.sv
// Bench for sdp_shared_fifo_ctrl: directed stimulus, a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_sdp_shared_fifo_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 40;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr0_valid, wr1_valid, rd_ready;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          wr0_ready, wr1_ready, rd_valid, full, empty;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  sdp_shared_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr0_valid (wr0_valid),
    .wr0_data  (wr0_data),
    .wr0_ready (wr0_ready),
    .wr1_valid (wr1_valid),
    .wr1_data  (wr1_data),
    .wr1_ready (wr1_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted word with the edge index at which it was
  // accepted. A word is readable once two edges have passed since acceptance;
  // the oldest word is the head.
  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } ent_t;

  ent_t mq[$];
  int   edge_n = 0;
  logic m_last = 1'b1;

  function automatic logic m_rd_valid();
    return (mq.size() > 0) && ((edge_n - mq[0].e) >= 2);
  endfunction

  function automatic logic m_full();
    return mq.size() == DEPTH;
  endfunction

  function automatic logic m_grant();
    return !m_full() && (wr0_valid || wr1_valid);
  endfunction

  function automatic logic m_winner();
    if (wr0_valid && wr1_valid) return !m_last;
    return wr1_valid;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      m_last = 1'b1;
    end else begin
      logic p, g, w;
      ent_t n;
      p = m_rd_valid() && rd_ready;
      g = m_grant();
      w = m_winner();
      if (p) void'(mq.pop_front());
      if (g) begin
        n.d = w ? wr1_data : wr0_data;
        n.e = edge_n;
        mq.push_back(n);
        m_last = w;
      end
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rd_valid", 64'(rd_valid), 64'(m_rd_valid()));
      if (m_rd_valid()) chk("m_rd_data", 64'(rd_data), 64'(mq[0].d));
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_full", 64'(full), 64'(m_full()));
      chk("m_empty", 64'(empty), 64'(mq.size() == 0));
      chk("m_wr0_ready", 64'(wr0_ready), 64'(m_grant() && !m_winner()));
      chk("m_wr1_ready", 64'(wr1_ready), 64'(m_grant() && m_winner()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    rd_ready  = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, got;
    logic [DW-1:0] expw;
    resetn    = 1'b0;
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    rd_ready  = 1'b0;
    wr0_data  = '0;
    wr1_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset state
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr0_ready", 64'(wr0_ready), 64'd0);
    chk("rst_wr1_ready", 64'(wr1_ready), 64'd0);

    // Single word through an empty FIFO
    resetn = 1'b1; wr0_valid = 1'b1; wr0_data = 40'hA1; rd_ready = 1'b1;
    #1 chk("t1_wr0_ready_c0", 64'(wr0_ready), 64'd1);
    cyc(); wr0_valid = 1'b0;
    #1 chk("t1_rd_valid_c1", 64'(rd_valid), 64'd0);
    cyc();
    #1 chk("t1_rd_valid_c2", 64'(rd_valid), 64'd1);
    chk("t1_rd_data_c2", 64'(rd_data), 64'hA1);
    cyc();
    #1 chk("t1_empty_c3", 64'(empty), 64'd1);
    rd_ready = 1'b0;

    // Round-robin alternation, then ordered drain
    do_reset();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      wr0_valid = (i0 < 4); wr1_valid = (i1 < 4);
      wr0_data = 40'h100 + 40'(i0); wr1_data = 40'h200 + 40'(i1);
      #1;
      chk("rr_wr0_ready", 64'(wr0_ready), 64'(k % 2 == 0));
      chk("rr_wr1_ready", 64'(wr1_ready), 64'(k % 2 == 1));
      if (wr0_ready) i0++;
      if (wr1_ready) i1++;
      cyc();
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    #1 chk("rr_count8", 64'(count), 64'd8);
    rd_ready = 1'b1; got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rd_valid && got < 8) begin
        expw = ((got % 2) == 0) ? (40'h100 + 40'(got / 2)) : (40'h200 + 40'(got / 2));
        chk("rr_drain_data", 64'(rd_data), 64'(expw));
        got++;
      end
      cyc();
    end
    chk("rr_drain_n", 64'(got), 64'd8);
    rd_ready = 1'b0;

    // Fill to DEPTH, then pop-one full-blocking behaviour
    do_reset();
    wr1_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr1_data = 40'h3000 + 40'(i);
      cyc();
    end
    wr1_data = 40'h3FFF;
    #1;
    chk("full_flag", 64'(full), 64'd1);
    chk("full_wr1_ready", 64'(wr1_ready), 64'd0);
    chk("full_count", 64'(count), 64'd512);
    rd_ready = 1'b1;
    #1 chk("full_pop_blocked", 64'(wr1_ready), 64'd0);
    cyc(); rd_ready = 1'b0;
    #1 chk("full_after_pop_ready", 64'(wr1_ready), 64'd1);
    chk("full_after_pop_count", 64'(count), 64'd511);
    cyc();
    #1 chk("full_refill_count", 64'(count), 64'd512);
    chk("full_refill_flag", 64'(full), 64'd1);
    wr1_valid = 1'b0;

    // Steady state: one write and one pop every cycle across two wraps
    do_reset();
    wr0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr0_data = 40'h4000 + 40'(i);
      cyc();
    end
    wr0_valid = 1'b0;
    cyc(); cyc();
    wr0_valid = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      wr0_data = 40'h5000 + 40'(i);
      #1;
      chk("ss_count", 64'(count), 64'd3);
      chk("ss_rd_valid", 64'(rd_valid), 64'd1);
      cyc();
    end
    wr0_valid = 1'b0; rd_ready = 1'b0;

    // Back-pressure: head is word index 1100 = 0x5000 + 1097
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rd_valid", 64'(rd_valid), 64'd1);
      chk("bp_rd_data", 64'(rd_data), 64'h5449);
      cyc();
    end

    // Reset mid-operation with count=37, avail=36
    do_reset();
    wr0_valid = 1'b1;
    for (int i = 0; i < 37; i++) begin
      wr0_data = 40'h6000 + 40'(i);
      cyc();
    end
    wr0_valid = 1'b0; resetn = 1'b0;
    #1 chk("mid_count37", 64'(count), 64'd37);
    cyc(); resetn = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    wr0_valid = 1'b1; wr0_data = 40'h55; rd_ready = 1'b1;
    cyc(); wr0_valid = 1'b0;
    cyc();
    #1;
    chk("mid_new_rd_valid", 64'(rd_valid), 64'd1);
    chk("mid_new_rd_data", 64'(rd_data), 64'h55);
    cyc();
    rd_ready = 1'b0;
    cyc();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
